edge_frame_writer: RTL and testbench
====================================

Name: edge_frame_writer

Overview:
Consumer end of the edge-filter pixel stream. It accepts filtered pixels (8-bit value plus a one-cycle valid strobe) produced once per window position over a (W-2) x (H-2) output frame. Each pixel is optionally thresholded to binary, buffered in a small FIFO, and written row-major into the output frame memory through a write port with backpressure. The block reports frame completion and error status to the top-level controller, which later reads the memory out over UART.

Parameters:
ADDR_W, 16, width of the output memory address
FIFO_DEPTH, 4, entries in the input FIFO (power of 2)
DIM_W, 16, width of the W/H frame dimension inputs

Ports:
clk  input  1  clock
rstn  input  1  synchronous reset, active-low
start  input  1  one-cycle pulse; latches dims and base address, begins a frame
W  input  DIM_W  input image width (pixels)
H  input  DIM_W  input image height (pixels)
base_addr  input  ADDR_W  memory address of output pixel (0,0)
thresh_en  input  1  1 = binarize output
threshold  input  8  binarize level
pix_in  input  8  filtered pixel
pix_valid  input  1  pix_in valid this cycle; no backpressure toward the source
mem_we  output  1  write request; held until accepted
mem_addr  output  ADDR_W  write address
mem_wdata  output  8  write data
mem_ready  input  1  memory accepts the write when mem_we && mem_ready at a clock edge
busy  output  1  high in RUN
frame_done  output  1  one-cycle pulse after the last write is accepted
overflow  output  1  sticky; a pixel was dropped because the FIFO was full
cfg_err  output  1  sticky; start received with W<3 or H<3
out_col  output  DIM_W  column of the pixel currently on the write port
out_row  output  DIM_W  row of the pixel currently on the write port

Behaviour:
- Reset (rstn=0 at edge): state IDLE; FIFO emptied; all outputs 0. Applies mid-frame too; the partial frame is abandoned and no further writes occur.
- States: IDLE, RUN, DONE.
- IDLE:
  - pix_valid is ignored.
  - start with W>=3 and H>=3: latch ow=W-2, oh=H-2, total=ow*oh (2*DIM_W bits, computed once), base_addr, thresh_en, threshold. Clear in_cnt, wr_cnt, col, row, overflow. Go to RUN.
  - start with W<3 or H<3: set cfg_err and stay in IDLE.
  - Any accepted start clears cfg_err.
- RUN:
  - busy=1. start is ignored.
  - Push: when pix_valid and in_cnt<total, the pixel is pushed if the FIFO is not full, or if it is full and popping in the same cycle. Otherwise the pixel is dropped and overflow is set. in_cnt counts pushed pixels only.
  - pix_valid with in_cnt==total is ignored and does not set overflow.
  - Output stage: registered mem_we/mem_addr/mem_wdata. Loads from the FIFO head when the stage is empty, or when its current write is being accepted this edge (pop).
    - mem_wdata = thresh_en ? (pix>=threshold ? 8'hFF : 8'h00) : pix.
    - mem_addr = base + wr_cnt (modulo 2^ADDR_W).
    - addr, wdata, out_col and out_row are stable while mem_we=1 and mem_ready=0.
  - On acceptance: wr_cnt++. col increments; at ow-1 col wraps to 0 and row increments.
  - Latency: pixel sampled at edge N gives mem_we=1 after edge N+1. With mem_ready held high, throughput is 1 pixel/clk.
  - Capacity under a full stall is FIFO_DEPTH+1 pixels.
  - When the write with wr_cnt==total-1 is accepted: go to DONE and deassert mem_we.
- DONE: frame_done=1 for exactly one cycle, busy=0, then IDLE. overflow holds its value until the next accepted start.

Decomposition:
- Shared package edge_pkg: PIX_W=8, PIX_WHITE=8'hFF, PIX_BLACK=8'h00, state enum {IDLE, RUN, DONE}.
- One sub-module edge_fifo: synchronous FIFO, DEPTH param, push/pop/full/empty/head. Push-when-full is allowed only with a simultaneous pop, and the full check is done in the parent.

Test Plan:
- Basic frame: W=5, H=4, base=0x0100, thresh_en=0, mem_ready=1, six pixels 0x10..0x15 on consecutive cycles -> writes to 0x0100..0x0105 with data 0x10..0x15; out_col/out_row go (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); frame_done pulses once, one cycle after the last write; overflow=0.
- Threshold: thresh_en=1, threshold=200, pixels 199, 200, 255, 0 -> wdata 0x00, 0xFF, 0xFF, 0x00.
- Backpressure: mem_ready=0 for 10 cycles, 7 consecutive pixels, FIFO_DEPTH=4 -> first 5 stored, pixels 6 and 7 dropped, overflow=1; mem_addr/wdata held steady while stalled; after release, exactly 5 writes in order.
- Config error: start with W=2, H=10 -> cfg_err=1, busy=0, no mem_we; a following start with W=4, H=4 clears cfg_err and busy=1.
- Extra and ignored inputs: W=H=3 (1 pixel), send 3 pixels -> one write, overflow=0; a start pulse during RUN has no effect.
- Reset mid-frame: rstn=0 after 3 of 6 writes -> next cycle mem_we=0, busy=0, all flags 0; a new start runs a clean frame from base_addr.

Source files
------------

// File: rtl/edge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : edge_pkg
// Description : Shared types and constants for the edge-filter frame writer.
// Revision    : 1.0 - initial release
// ============================================================================
package edge_pkg;

    localparam int PIX_W = 8;
    localparam logic [PIX_W-1:0] PIX_WHITE = 8'hFF;
    localparam logic [PIX_W-1:0] PIX_BLACK = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Optional binarization of a filtered pixel against a level.
    function automatic logic [PIX_W-1:0] binarize(
        input logic [PIX_W-1:0] pix,
        input logic             en,
        input logic [PIX_W-1:0] level
    );
        if (!en) begin
            return pix;
        end
        return (pix >= level) ? PIX_WHITE : PIX_BLACK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_frame_writer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : edge_fifo
// Description : Small synchronous FIFO with combinational head output.
//               Push while full is legal only together with a pop; the
//               parent enforces that rule.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_fifo
    import edge_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = PIX_W
)(
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    assign full  = (r_count == (c_ptr_w+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because r_count gates validity.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/edge_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : edge_frame_writer
// Description : Collects filtered pixels of a (W-2)x(H-2) frame, optionally
//               binarizes them, buffers them and writes them row-major to
//               the output frame memory through a ready/valid write port.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_frame_writer
    import edge_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DIM_W      = 16
)(
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [DIM_W-1:0]  W,
    input  logic [DIM_W-1:0]  H,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              thresh_en,
    input  logic [PIX_W-1:0]  threshold,
    input  logic [PIX_W-1:0]  pix_in,
    input  logic              pix_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic              cfg_err,
    output logic [DIM_W-1:0]  out_col,
    output logic [DIM_W-1:0]  out_row
);

    localparam int c_cnt_w = 2 * DIM_W;

    state_t             r_state;
    logic [DIM_W-1:0]   r_ow;
    logic [DIM_W-1:0]   r_col;
    logic [DIM_W-1:0]   r_row;
    logic [c_cnt_w-1:0] r_total;
    logic [c_cnt_w-1:0] r_in_cnt;
    logic [c_cnt_w-1:0] r_wr_cnt;
    logic               r_thr_en;
    logic [PIX_W-1:0]   r_thr;
    logic [ADDR_W-1:0]  r_addr;
    logic [PIX_W-1:0]   r_wdata;
    logic               r_we;
    logic               r_busy;
    logic               r_done;
    logic               r_overflow;
    logic               r_cfg_err;

    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [PIX_W-1:0]   w_fifo_head;
    logic               w_run;
    logic               w_accept;
    logic               w_pop;
    logic               w_want;
    logic               w_push;
    logic               w_drop;
    logic               w_last;
    logic               w_col_wrap;
    logic               w_cfg_ok;
    logic [DIM_W-1:0]   w_ow;
    logic [DIM_W-1:0]   w_oh;
    logic [c_cnt_w-1:0] w_total;

    assign w_ow     = W - DIM_W'(2);
    assign w_oh     = H - DIM_W'(2);
    assign w_total  = c_cnt_w'(w_ow) * c_cnt_w'(w_oh);
    assign w_cfg_ok = (W >= DIM_W'(3)) && (H >= DIM_W'(3));

    assign w_run      = (r_state == RUN);
    assign w_accept   = w_run && r_we && mem_ready;
    // The output stage refills when it is empty or its write retires this edge.
    assign w_pop      = w_run && !w_fifo_empty && (!r_we || mem_ready);
    assign w_want     = w_run && pix_valid && (r_in_cnt < r_total);
    assign w_push     = w_want && (!w_fifo_full || w_pop);
    assign w_drop     = w_want && !w_push;
    assign w_last     = (r_wr_cnt == (r_total - c_cnt_w'(1)));
    assign w_col_wrap = (r_col == (r_ow - DIM_W'(1)));

    edge_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_push),
        .pop   (w_pop),
        .din   (pix_in),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .head  (w_fifo_head)
    );

    // Frame control FSM together with the registered write port and status.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_ow       <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_total    <= '0;
            r_in_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_thr_en   <= 1'b0;
            r_thr      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            r_ow       <= w_ow;
                            r_total    <= w_total;
                            r_addr     <= base_addr;
                            r_thr_en   <= thresh_en;
                            r_thr      <= threshold;
                            r_in_cnt   <= '0;
                            r_wr_cnt   <= '0;
                            r_col      <= '0;
                            r_row      <= '0;
                            r_overflow <= 1'b0;
                            r_cfg_err  <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= RUN;
                        end else begin
                            r_cfg_err  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_push) begin
                        r_in_cnt <= r_in_cnt + c_cnt_w'(1);
                    end else if (w_drop) begin
                        r_overflow <= 1'b1;
                    end
                    if (w_accept) begin
                        r_wr_cnt <= r_wr_cnt + c_cnt_w'(1);
                        r_addr   <= r_addr + ADDR_W'(1);
                        if (w_col_wrap) begin
                            r_col <= '0;
                            r_row <= r_row + DIM_W'(1);
                        end else begin
                            r_col <= r_col + DIM_W'(1);
                        end
                    end
                    if (w_accept && w_last) begin
                        r_we    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (w_pop) begin
                        r_we    <= 1'b1;
                        r_wdata <= binarize(w_fifo_head, r_thr_en, r_thr);
                    end else if (w_accept) begin
                        r_we    <= 1'b0;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign overflow   = r_overflow;
    assign cfg_err    = r_cfg_err;
    assign out_col    = r_col;
    assign out_row    = r_row;

endmodule
`default_nettype wire

// File: tb/tb_edge_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_frame_writer
// Description : Self-checking bench for edge_frame_writer: table of frames
//               plus hand-written backpressure, config, restart and reset
//               sequences, with a write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_frame_writer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] W = '0;
    logic [15:0] H = '0;
    logic [15:0] base_addr = '0;
    logic        thresh_en = 1'b0;
    logic [7:0]  threshold = '0;
    logic [7:0]  pix_in = '0;
    logic        pix_valid = 1'b0;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready = 1'b1;
    logic        busy;
    logic        frame_done;
    logic        overflow;
    logic        cfg_err;
    logic [15:0] out_col;
    logic [15:0] out_row;

    always #5 clk = ~clk;

    edge_frame_writer #(
        .ADDR_W     (16),
        .FIFO_DEPTH (4),
        .DIM_W      (16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .W          (W),
        .H          (H),
        .base_addr  (base_addr),
        .thresh_en  (thresh_en),
        .threshold  (threshold),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow),
        .cfg_err    (cfg_err),
        .out_col    (out_col),
        .out_row    (out_row)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [15:0] col;
        logic [15:0] row;
    } exp_t;

    typedef struct {
        logic [15:0]     w;
        logic [15:0]     h;
        logic [15:0]     base;
        logic            ten;
        logic [7:0]      thr;
        int              nsent;
        int              nwr;
        logic [5:0][7:0] pix;
        logic [5:0][7:0] expd;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[4];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   last_acc = -10;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [7:0] d,
                            input logic [15:0] c, input logic [15:0] r);
        exp_t e;
        e.addr = a; e.data = d; e.col = c; e.row = r;
        sb.push_back(e);
    endtask

    // Observe the DUT on the falling edge; an accepted write is one seen with
    // mem_we && mem_ready here, since inputs only change just after rising edges.
    task automatic monitor();
        exp_t e;
        if (mem_we && mem_ready) begin
            last_acc = cyc;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected actual addr=%h data=%h required none", mem_addr, mem_wdata);
            end else begin
                e = sb.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data || out_col !== e.col || out_row !== e.row) begin
                    errors++;
                    $display("FAIL write actual addr=%h data=%h col=%0d row=%0d required addr=%h data=%h col=%0d row=%0d",
                             mem_addr, mem_wdata, out_col, out_row, e.addr, e.data, e.col, e.row);
                end
            end
        end
        if (frame_done) begin
            done_cnt++;
            chk("done_latency", cyc, last_acc + 1);
            chk("done_busy", {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while (!frame_done && n < maxc) begin
            tick();
            n++;
        end
        if (!frame_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=0 required=1 within %0d cycles", maxc);
        end
    endtask

    task automatic do_start(input logic [15:0] w, input logic [15:0] h, input logic [15:0] b,
                            input logic te, input logic [7:0] th);
        W = w; H = h; base_addr = b; thresh_en = te; threshold = th;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        int ow = int'(v.w) - 2;
        int d0 = done_cnt;
        mem_ready = 1'b1;
        do_start(v.w, v.h, v.base, v.ten, v.thr);
        chk("frame_busy", {31'd0, busy}, 32'd1);
        chk("frame_ovf_clear", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < v.nsent; i++) begin
            pix_in = v.pix[i];
            pix_valid = 1'b1;
            if (i < v.nwr)
                push_exp(v.base + 16'(i), v.expd[i], 16'(i % ow), 16'(i / ow));
            tick();
        end
        pix_valid = 1'b0;
        wait_done(40);
        tick();
        tick();
        chk("frame_done_count", done_cnt - d0, 32'd1);
        chk("frame_sb_empty", sb.size(), 32'd0);
        chk("frame_overflow", {31'd0, overflow}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{w:16'd5, h:16'd4, base:16'h0100, ten:1'b0, thr:8'd0, nsent:6, nwr:6,
                    pix:{8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10},
                    expd:{8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10}};
        vecs[1] = '{w:16'd4, h:16'd4, base:16'h0200, ten:1'b1, thr:8'd200, nsent:4, nwr:4,
                    pix:{8'h00, 8'h00, 8'd0, 8'd255, 8'd200, 8'd199},
                    expd:{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00}};
        vecs[2] = '{w:16'd3, h:16'd3, base:16'h0300, ten:1'b0, thr:8'd0, nsent:3, nwr:1,
                    pix:{8'h00, 8'h00, 8'h00, 8'h02, 8'h01, 8'h7F},
                    expd:{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F}};
        vecs[3] = '{w:16'd4, h:16'd3, base:16'hFFFF, ten:1'b0, thr:8'd0, nsent:2, nwr:2,
                    pix:{8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'hAA},
                    expd:{8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'hAA}};

        // Reset state
        rstn = 1'b0;
        tick();
        tick();
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_flags", {30'd0, overflow, cfg_err}, 32'd0);
        chk("rst_addr_data", {8'd0, mem_addr, mem_wdata}, 32'd0);
        chk("rst_col_row", {out_col, out_row}, 32'd0);
        rstn = 1'b1;
        tick();

        // Table-driven frames: basic, threshold, extra pixels, address wrap
        for (int k = 0; k < 4; k++) begin
            run_frame(vecs[k]);
        end

        // Backpressure: 7 pixels into a fully stalled write port
        mem_ready = 1'b0;
        do_start(16'd5, 16'd4, 16'h0400, 1'b0, 8'd0);
        for (int i = 0; i < 10; i++) begin
            if (i < 7) begin
                pix_in = 8'h21 + 8'(i);
                pix_valid = 1'b1;
                if (i < 5)
                    push_exp(16'h0400 + 16'(i), 8'h21 + 8'(i), 16'(i % 3), 16'(i / 3));
            end else begin
                pix_valid = 1'b0;
            end
            tick();
            if (i >= 1) begin
                chk("bp_hold_we", {31'd0, mem_we}, 32'd1);
                chk("bp_hold_addr_data", {8'd0, mem_addr, mem_wdata}, {8'd0, 16'h0400, 8'h21});
            end
        end
        pix_valid = 1'b0;
        chk("bp_overflow", {31'd0, overflow}, 32'd1);
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("bp_drained", sb.size(), 32'd0);
        chk("bp_still_busy", {31'd0, busy}, 32'd1);
        pix_in = 8'h28;
        pix_valid = 1'b1;
        push_exp(16'h0405, 8'h28, 16'd2, 16'd1);
        tick();
        pix_valid = 1'b0;
        wait_done(20);
        tick();
        tick();
        chk("bp_sb_empty", sb.size(), 32'd0);
        chk("bp_overflow_held", {31'd0, overflow}, 32'd1);

        // Config error, then a valid start clears it
        do_start(16'd2, 16'd10, 16'h0000, 1'b0, 8'd0);
        chk("cfg_err_set", {31'd0, cfg_err}, 32'd1);
        chk("cfg_err_busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        chk("cfg_err_no_we", {31'd0, mem_we}, 32'd0);
        do_start(16'd4, 16'd4, 16'h0700, 1'b0, 8'd0);
        chk("cfg_err_cleared", {31'd0, cfg_err}, 32'd0);
        chk("cfg_busy", {31'd0, busy}, 32'd1);
        chk("cfg_ovf_cleared", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            pix_in = 8'h31 + 8'(i);
            pix_valid = 1'b1;
            push_exp(16'h0700 + 16'(i), 8'h31 + 8'(i), 16'(i % 2), 16'(i / 2));
            tick();
        end
        pix_valid = 1'b0;
        wait_done(20);
        tick();
        chk("cfg_sb_empty", sb.size(), 32'd0);

        // A start pulse during RUN must not disturb the frame
        do_start(16'd5, 16'd4, 16'h0500, 1'b0, 8'd0);
        W = 16'd3; H = 16'd3; base_addr = 16'h0000; thresh_en = 1'b1; threshold = 8'd1;
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pix_in = 8'h50 + 8'(i);
            pix_valid = 1'b1;
            push_exp(16'h0500 + 16'(i), 8'h50 + 8'(i), 16'(i % 3), 16'(i / 3));
            tick();
            start = 1'b0;
        end
        pix_valid = 1'b0;
        chk("rs_busy", {31'd0, busy}, 32'd1);
        wait_done(20);
        tick();
        chk("rs_sb_empty", sb.size(), 32'd0);

        // Reset mid-frame after 3 of the writes
        mem_ready = 1'b0;
        do_start(16'd5, 16'd4, 16'h0600, 1'b0, 8'd0);
        for (int i = 0; i < 7; i++) begin
            pix_in = 8'h41 + 8'(i);
            pix_valid = 1'b1;
            if (i < 3)
                push_exp(16'h0600 + 16'(i), 8'h41 + 8'(i), 16'(i % 3), 16'(i / 3));
            tick();
        end
        pix_valid = 1'b0;
        chk("mr_overflow_pre", {31'd0, overflow}, 32'd1);
        mem_ready = 1'b1;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("mr_we", {31'd0, mem_we}, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_flags", {29'd0, overflow, cfg_err, frame_done}, 32'd0);
        chk("mr_sb_empty", sb.size(), 32'd0);
        mem_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("mr_no_more_we", {31'd0, mem_we}, 32'd0);
        run_frame(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
